// File: rtl/subtractor_nbit_serial.sv
// Bit-serial A - B, LSB first, built on one time-multiplexed adder_1bit cell.
// Optional signed-overflow output Ovf is enabled by SUBTRACTOR_NBIT_SERIAL_OVF_EN.

module adder_1bit #(
  parameter int IMPL_TYPE = 0
) (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  generate
    if (IMPL_TYPE == 0) begin : g_gate
      assign sum  = a ^ b ^ cin;
      assign cout = (a & b) | (cin & (a ^ b));
    end else begin : g_behav
      logic [1:0] total;
      assign total = {1'b0, a} + {1'b0, b} + {1'b0, cin};
      assign sum   = total[0];
      assign cout  = total[1];
    end
  endgenerate
endmodule

module subtractor_nbit_serial #(
  parameter int WIDTH     = 32,
  parameter int IMPL_TYPE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow
`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
  ,
  output logic             Ovf
`endif
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] sa_reg, sa_next;
  logic [WIDTH-1:0] sb_reg, sb_next;
  logic [WIDTH-1:0] sd_reg, sd_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic [WIDTH-1:0] sd_shift;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic             c_reg, c_next;
  logic             done_reg, done_next;
  logic             borrow_reg, borrow_next;
  logic             sum, cout;

  // Subtraction as A + ~B + 1: the +1 comes from presetting the carry.
  adder_1bit #(.IMPL_TYPE(IMPL_TYPE)) u_cell (
    .a    (sa_reg[0]),
    .b    (~sb_reg[0]),
    .cin  (c_reg),
    .sum  (sum),
    .cout (cout)
  );

`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
  logic ovf_reg, ovf_next;
  assign Ovf = ovf_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      sa_reg     <= '0;
      sb_reg     <= '0;
      sd_reg     <= '0;
      diff_reg   <= '0;
      cnt_reg    <= '0;
      c_reg      <= 1'b0;
      done_reg   <= 1'b0;
      borrow_reg <= 1'b0;
`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
      ovf_reg    <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      sa_reg     <= sa_next;
      sb_reg     <= sb_next;
      sd_reg     <= sd_next;
      diff_reg   <= diff_next;
      cnt_reg    <= cnt_next;
      c_reg      <= c_next;
      done_reg   <= done_next;
      borrow_reg <= borrow_next;
`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
      ovf_reg    <= ovf_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    sa_next     = sa_reg;
    sb_next     = sb_reg;
    sd_next     = sd_reg;
    diff_next   = diff_reg;
    cnt_next    = cnt_reg;
    c_next      = c_reg;
    done_next   = 1'b0;
    borrow_next = borrow_reg;
`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
    ovf_next    = ovf_reg;
`endif
    sd_shift           = sd_reg >> 1;
    sd_shift[WIDTH-1]  = sum;

    case (state_reg)
      IDLE: begin
        if (start) begin
          sa_next    = A;
          sb_next    = B;
          c_next     = 1'b1;
          cnt_next   = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        sa_next  = sa_reg >> 1;
        sb_next  = sb_reg >> 1;
        sd_next  = sd_shift;
        c_next   = cout;
        cnt_next = cnt_reg + CW'(1);
        if (cnt_reg == LAST) begin
          // c_reg is the carry into the MSB on this final cycle.
          diff_next   = sd_shift;
          borrow_next = ~cout;
`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
          ovf_next    = c_reg ^ cout;
`endif
          done_next   = 1'b1;
          cnt_next    = '0;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy   = (state_reg == RUN);
  assign done   = done_reg;
  assign Diff   = diff_reg;
  assign Borrow = borrow_reg;
endmodule

// File: tb/tb_subtractor_nbit_serial.sv
// Directed bench for subtractor_nbit_serial (WIDTH=8 and WIDTH=1 instances);
// Ovf checks are compiled in when SUBTRACTOR_NBIT_SERIAL_OVF_EN is defined.

module tb_subtractor_nbit_serial;
  logic       clk = 1'b0;
  logic       rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic [0:0] a1, b1;
  logic       busy8, done8, borrow8;
  logic       busy1, done1, borrow1;
  logic [7:0] diff8;
  logic [0:0] diff1;
`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
  logic       ovf8, ovf1;
`endif

  int checks = 0;
  int errors = 0;
  int n;
  int pulses;

  always #5 clk = ~clk;

  subtractor_nbit_serial #(.WIDTH(8), .IMPL_TYPE(0)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .Diff(diff8), .Borrow(borrow8)
`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
    , .Ovf(ovf8)
`endif
  );

  subtractor_nbit_serial #(.WIDTH(1), .IMPL_TYPE(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(a1), .B(b1),
    .busy(busy1), .done(done1), .Diff(diff1), .Borrow(borrow1)
`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
    , .Ovf(ovf1)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Start one 8-bit op at edge E0 and return the number of edges until done (0 = timeout).
  task automatic run8(input logic [7:0] a, input logic [7:0] b, output int edges);
    @(negedge clk);
    a8 = a; b8 = b; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    edges = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        edges = i;
        break;
      end
    end
    $display("op A=%0d B=%0d -> Diff=%0d Borrow=%0d after %0d edges", a, b, diff8, borrow8, edges);
  endtask

  initial begin
    rst = 1'b1; start8 = 1'b0; start1 = 1'b0;
    a8 = '0; b8 = '0; a1 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy8, 0);
    chk("reset_done", done8, 0);
    chk("reset_diff", diff8, 0);
    chk("reset_borrow", borrow8, 0);
    @(negedge clk); rst = 1'b0;

    // 200 - 55
    run8(8'd200, 8'd55, n);
    chk("lat_200_55", n, 8);
    chk("diff_200_55", diff8, 145);
    chk("borrow_200_55", borrow8, 0);
    chk("busy_at_done", busy8, 0);
`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
    chk("ovf_200_55", ovf8, 0);
`endif
    @(posedge clk); #1;
    chk("done_single_cycle", done8, 0);
    chk("diff_held", diff8, 145);

    // 5 - 7
    run8(8'd5, 8'd7, n);
    chk("diff_5_7", diff8, 254);
    chk("borrow_5_7", borrow8, 1);
`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
    chk("ovf_5_7", ovf8, 0);
`endif

    // signed overflow cases
    run8(8'h80, 8'h01, n);
    chk("diff_80_01", diff8, 8'h7F);
    chk("borrow_80_01", borrow8, 0);
`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
    chk("ovf_80_01", ovf8, 1);
`endif
    run8(8'h7F, 8'hFF, n);
    chk("diff_7F_FF", diff8, 8'h80);
    chk("borrow_7F_FF", borrow8, 1);
`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
    chk("ovf_7F_FF", ovf8, 1);
`endif

    // start re-asserted during RUN must be ignored
    @(negedge clk);
    a8 = 8'd10; b8 = 8'd3; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    chk("busy_after_accept", busy8, 1);
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i >= 2 && i <= 4) begin a8 = 8'd99; b8 = 8'd1; start8 = 1'b1; end
      else start8 = 1'b0;
      @(posedge clk); #1;
      if (done8) pulses++;
      if (done8) $display("ignored-start test: done at edge %0d Diff=%0d", i, diff8);
    end
    chk("ignore_pulses", pulses, 1);
    chk("ignore_diff", diff8, 7);

    // reset asserted just before E4 aborts the op
    @(negedge clk);
    a8 = 8'd50; b8 = 8'd20; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", busy8, 0);
    chk("abort_diff", diff8, 0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done8) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    $display("abort test: busy=%0d Diff=%0d done pulses=%0d", busy8, diff8, pulses);
    run8(8'd9, 8'd9, n);
    chk("diff_9_9", diff8, 0);
    chk("borrow_9_9", borrow8, 0);

    // continuous start
    @(negedge clk);
    a8 = 8'd3; b8 = 8'd1; start8 = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (done8) begin
        pulses++;
        $display("continuous: done at edge %0d Diff=%0d", i, diff8);
        chk("cont_diff", diff8, 2);
      end
    end
    @(negedge clk); start8 = 1'b0;
    chk("cont_pulses", pulses, 3);

    // WIDTH = 1: 0 - 1
    @(negedge clk);
    a1 = 1'b0; b1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("w1_busy", busy1, 1);
    @(posedge clk); #1;
    chk("w1_done", done1, 1);
    chk("w1_diff", diff1, 1);
    chk("w1_borrow", borrow1, 1);
`ifdef SUBTRACTOR_NBIT_SERIAL_OVF_EN
    chk("w1_ovf", ovf1, 1);
`endif
    $display("width1 op A=0 B=1 -> Diff=%0d Borrow=%0d", diff1, borrow1);
    @(posedge clk); #1;
    chk("w1_done_drop", done1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
